// File: rtl/dram_responder.sv
// Processor-facing data memory with a fixed-latency read path, single-cycle
// write completion, a sticky error flag and a host port for image preload/readback.
module dram_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] din,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] d_out,
  output logic              ready,
  output logic              busy,
  output logic              err,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_din,
  output logic [DATA_W-1:0] host_dout
);

  // state   | meaning
  // IDLE    | accepting processor requests and host writes
  // RD_WAIT | read address captured, latency counter running
  // RD_DONE | read data valid on d_out, ready strobe
  // WR_DONE | write committed on the capture edge, ready strobe

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW1 = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_L = AW1'(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE, WR_DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  cap_idx;
  logic              cap_oor;

  logic addr_ok, host_ok, is_idle;
  logic rd_req, wr_req, conflict, proc_req;
  logic proc_wr, host_wr, host_drop, rd_load;

  assign addr_ok   = {1'b0, addr_in} < DEPTH_L;
  assign host_ok   = {1'b0, host_addr} < DEPTH_L;
  assign is_idle   = (state == IDLE);
  assign proc_req  = read | write;
  assign rd_req    = is_idle & read & ~write;
  assign wr_req    = is_idle & write & ~read;
  assign conflict  = is_idle & read & write;
  assign proc_wr   = wr_req & addr_ok;
  assign host_wr   = host_we & is_idle & ~proc_req & host_ok;
  // Host writes lose to anything the processor is doing, and that loss is flagged.
  assign host_drop = host_we & (~is_idle | proc_req);
  assign rd_load   = (state == RD_WAIT) && (cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_req)      state_nxt = RD_WAIT;
        else if (wr_req) state_nxt = WR_DONE;
      end
      RD_WAIT: if (cnt == 4'd0) state_nxt = RD_DONE;
      RD_DONE: state_nxt = IDLE;
      WR_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b1;
    case (state)
      IDLE:    busy  = 1'b0;
      RD_DONE: ready = 1'b1;
      WR_DONE: ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= 4'd0;
      cap_idx   <= '0;
      cap_oor   <= 1'b0;
      d_out     <= '0;
      host_dout <= '0;
      err       <= 1'b0;
    end else begin
      if (rd_req) begin
        cnt     <= CNT_INIT;
        cap_idx <= addr_in[IDX_W-1:0];
        cap_oor <= ~addr_ok;
      end else if ((state == RD_WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (rd_load) d_out <= cap_oor ? '0 : mem[cap_idx];
      host_dout <= host_ok ? mem[host_addr[IDX_W-1:0]] : '0;
      if (conflict | ((rd_req | wr_req) & ~addr_ok) | host_drop) err <= 1'b1;
    end
  end

  // Storage has no reset so a preloaded image survives rst_n.
  always_ff @(posedge clk) begin
    if (proc_wr)      mem[addr_in[IDX_W-1:0]]   <= din;
    else if (host_wr) mem[host_addr[IDX_W-1:0]] <= host_din;
  end

endmodule

// File: tb/tb_dram_responder.sv
// Randomized and directed checks of dram_responder against a flat-array memory model.
module tb_dram_responder;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;
  localparam int RD_CYC = RD_LAT + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] addr_in, host_addr;
  logic [DATA_W-1:0] din, host_din, d_out, host_dout;
  logic              read, write, ready, busy, err, host_we;

  int n_cmp = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] model [DEPTH];
  logic model_err;

  dram_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .din(din), .read(read), .write(write),
    .d_out(d_out), .ready(ready), .busy(busy), .err(err), .host_we(host_we),
    .host_addr(host_addr), .host_din(host_din), .host_dout(host_dout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; read = 1'b0; write = 1'b0; host_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_err = 1'b0;
    tick();
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    host_we = 1'b1; host_addr = a; host_din = d;
    tick();
    host_we = 1'b0;
    if (int'(a) < DEPTH) model[int'(a)] = d;
  endtask

  // Issues one processor request and reports the edge count from capture to the
  // edge that samples ready, plus the number of cycles busy was high.
  task automatic proc_op(input bit is_wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input bit hold, output int lat, output int bcnt);
    int n;
    addr_in = a; din = d; read = ~is_wr; write = is_wr;
    tick();
    if (!hold) begin
      read = 1'b0; write = 1'b0;
      addr_in = ADDR_W'($urandom); din = DATA_W'($urandom);
    end
    n = 0;
    bcnt = busy ? 1 : 0;
    while (!ready && n < 40) begin
      tick();
      n++;
      if (busy) bcnt++;
    end
    lat = ready ? n + 1 : -1;
    tick();
    if (busy) bcnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; read = 1'b0; write = 1'b0; host_we = 1'b0;
    addr_in = '0; din = '0; host_addr = '0; host_din = '0;
    #1 rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (ready !== 1'b0) begin $display("FAIL reset_ready got %b want 0", ready); n_fail++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_fail++; end
    n_cmp++; if (err !== 1'b0) begin $display("FAIL reset_err got %b want 0", err); n_fail++; end
    n_cmp++; if (d_out !== 8'h00) begin $display("FAIL reset_dout got %h want 00", d_out); n_fail++; end
    n_cmp++; if (host_dout !== 8'h00) begin $display("FAIL reset_hostdout got %h want 00", host_dout); n_fail++; end
    @(negedge clk) rst_n = 1'b1;
    model_err = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) host_write(ADDR_W'(i), DATA_W'($urandom));
  endtask

  task automatic test_preload_read();
    int lat, bc;
    host_write(16'h0005, 8'hA7);
    proc_op(1'b0, 16'h0005, 8'h00, 1'b0, lat, bc);
    n_cmp++; if (lat != RD_CYC) begin $display("FAIL preload_rd_lat got %0d want %0d", lat, RD_CYC); n_fail++; end
    n_cmp++; if (bc != RD_CYC) begin $display("FAIL preload_rd_busy got %0d want %0d", bc, RD_CYC); n_fail++; end
    n_cmp++; if (d_out !== 8'hA7) begin $display("FAIL preload_rd_data got %h want a7", d_out); n_fail++; end
    n_cmp++; if (err !== model_err) begin $display("FAIL preload_rd_err got %b want %b", err, model_err); n_fail++; end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    proc_op(1'b1, 16'h0010, 8'h3C, 1'b1, lat, bc);
    model[16] = 8'h3C;
    n_cmp++; if (lat != 1) begin $display("FAIL b2b_wr_lat got %0d want 1", lat); n_fail++; end
    write = 1'b0;
    proc_op(1'b0, 16'h0010, 8'h00, 1'b1, lat, bc);
    n_cmp++; if (lat != RD_CYC) begin $display("FAIL b2b_rd_lat got %0d want %0d", lat, RD_CYC); n_fail++; end
    n_cmp++; if (d_out !== 8'h3C) begin $display("FAIL b2b_rd_data got %h want 3c", d_out); n_fail++; end
    // read still held: next request is captured straight out of IDLE
    proc_op(1'b0, 16'h0005, 8'h00, 1'b0, lat, bc);
    n_cmp++; if (lat != RD_CYC) begin $display("FAIL b2b_rd2_lat got %0d want %0d", lat, RD_CYC); n_fail++; end
    n_cmp++; if (d_out !== model[5]) begin $display("FAIL b2b_rd2_data got %h want %h", d_out, model[5]); n_fail++; end
    // d_out holds across a write
    proc_op(1'b1, 16'h0011, 8'h99, 1'b0, lat, bc);
    model[17] = 8'h99;
    n_cmp++; if (d_out !== model[5]) begin $display("FAIL dout_hold got %h want %h", d_out, model[5]); n_fail++; end
  endtask

  task automatic test_conflict();
    do_reset();
    addr_in = 16'h0020; din = ~model[32]; read = 1'b1; write = 1'b1;
    tick();
    model_err = 1'b1;
    n_cmp++; if (ready !== 1'b0) begin $display("FAIL conflict_ready got %b want 0", ready); n_fail++; end
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL conflict_busy got %b want 0", busy); n_fail++; end
    n_cmp++; if (err !== 1'b1) begin $display("FAIL conflict_err got %b want 1", err); n_fail++; end
    read = 1'b0; write = 1'b0; host_addr = 16'h0020;
    tick();
    n_cmp++; if (host_dout !== model[32]) begin $display("FAIL conflict_mem got %h want %h", host_dout, model[32]); n_fail++; end
  endtask

  task automatic test_out_of_range();
    int lat, bc;
    do_reset();
    proc_op(1'b0, 16'h0400, 8'h00, 1'b0, lat, bc);
    n_cmp++; if (lat != RD_CYC) begin $display("FAIL oor_rd_lat got %0d want %0d", lat, RD_CYC); n_fail++; end
    n_cmp++; if (d_out !== 8'h00) begin $display("FAIL oor_rd_data got %h want 00", d_out); n_fail++; end
    n_cmp++; if (err !== 1'b1) begin $display("FAIL oor_rd_err got %b want 1", err); n_fail++; end
    do_reset();
    proc_op(1'b1, 16'h0400, ~model[0], 1'b0, lat, bc);
    n_cmp++; if (lat != 1) begin $display("FAIL oor_wr_lat got %0d want 1", lat); n_fail++; end
    n_cmp++; if (err !== 1'b1) begin $display("FAIL oor_wr_err got %b want 1", err); n_fail++; end
    host_addr = 16'h0000;
    tick();
    n_cmp++; if (host_dout !== model[0]) begin $display("FAIL oor_wr_mem got %h want %h", host_dout, model[0]); n_fail++; end
    do_reset();
    host_write(16'h8001, 8'h55);
    n_cmp++; if (err !== 1'b0) begin $display("FAIL oor_host_err got %b want 0", err); n_fail++; end
  endtask

  task automatic test_reset_mid_read();
    int lat, bc;
    do_reset();
    host_write(16'h0033, 8'h5A);
    proc_op(1'b0, 16'h0033, 8'h00, 1'b0, lat, bc);
    read = 1'b1; write = 1'b1; tick(); read = 1'b0; write = 1'b0;
    addr_in = 16'h0033; read = 1'b1;
    tick();
    read = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b1) begin $display("FAIL midrst_pre_busy got %b want 1", busy); n_fail++; end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin $display("FAIL midrst_busy got %b want 0", busy); n_fail++; end
    n_cmp++; if (ready !== 1'b0) begin $display("FAIL midrst_ready got %b want 0", ready); n_fail++; end
    n_cmp++; if (d_out !== 8'h00) begin $display("FAIL midrst_dout got %h want 00", d_out); n_fail++; end
    n_cmp++; if (err !== 1'b0) begin $display("FAIL midrst_err got %b want 0", err); n_fail++; end
    n_cmp++; if (host_dout !== 8'h00) begin $display("FAIL midrst_hostdout got %h want 00", host_dout); n_fail++; end
    @(negedge clk) rst_n = 1'b1;
    model_err = 1'b0;
    tick();
    proc_op(1'b0, 16'h0033, 8'h00, 1'b0, lat, bc);
    n_cmp++; if (d_out !== 8'h5A) begin $display("FAIL midrst_reread got %h want 5a", d_out); n_fail++; end
  endtask

  task automatic test_host_during_read();
    int n;
    do_reset();
    host_write(16'h0077, 8'hC3);
    addr_in = 16'h0077; read = 1'b1;
    tick();
    read = 1'b0;
    host_we = 1'b1; host_addr = 16'h0077; host_din = 8'h3C;
    tick();
    host_we = 1'b0;
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    n_cmp++; if (ready !== 1'b1) begin $display("FAIL hostrd_ready got %b want 1 (timeout)", ready); n_fail++; end
    n_cmp++; if (d_out !== 8'hC3) begin $display("FAIL hostrd_data got %h want c3", d_out); n_fail++; end
    n_cmp++; if (err !== 1'b1) begin $display("FAIL hostrd_err got %b want 1", err); n_fail++; end
    tick();
    n_cmp++; if (host_dout !== 8'hC3) begin $display("FAIL hostrd_mem got %h want c3", host_dout); n_fail++; end
    // coincident host write and processor write: processor wins
    do_reset();
    addr_in = 16'h0100; din = 8'hE1; write = 1'b1;
    host_we = 1'b1; host_addr = 16'h0101; host_din = ~model[257];
    tick();
    write = 1'b0; host_we = 1'b0;
    model[256] = 8'hE1;
    n_cmp++; if (err !== 1'b1) begin $display("FAIL coinc_err got %b want 1", err); n_fail++; end
    tick();
    n_cmp++; if (host_dout !== model[257]) begin $display("FAIL coinc_host_mem got %h want %h", host_dout, model[257]); n_fail++; end
    host_addr = 16'h0100;
    tick();
    n_cmp++; if (host_dout !== 8'hE1) begin $display("FAIL coinc_proc_mem got %h want e1", host_dout); n_fail++; end
  endtask

  task automatic test_random();
    int lat, bc, kind;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, exp_d;
    do_reset();
    for (int it = 0; it < 120; it++) begin
      kind = $urandom_range(0, 3);
      d = DATA_W'($urandom);
      if ($urandom_range(0, 7) == 0) a = ADDR_W'(DEPTH + $urandom_range(0, 65535 - DEPTH));
      else a = ADDR_W'($urandom_range(0, DEPTH - 1));
      case (kind)
        0: host_write(a, d);
        1: begin
          proc_op(1'b1, a, d, 1'b0, lat, bc);
          if (int'(a) < DEPTH) model[int'(a)] = d;
          else model_err = 1'b1;
          n_cmp++; if (lat != 1) begin $display("FAIL rnd_wr_lat it=%0d got %0d want 1", it, lat); n_fail++; end
        end
        2: begin
          proc_op(1'b0, a, d, 1'b0, lat, bc);
          exp_d = (int'(a) < DEPTH) ? model[int'(a)] : '0;
          if (int'(a) >= DEPTH) model_err = 1'b1;
          n_cmp++; if (lat != RD_CYC) begin $display("FAIL rnd_rd_lat it=%0d got %0d want %0d", it, lat, RD_CYC); n_fail++; end
          n_cmp++; if (d_out !== exp_d) begin $display("FAIL rnd_rd_data it=%0d addr=%h got %h want %h", it, a, d_out, exp_d); n_fail++; end
        end
        default: begin
          a = ADDR_W'($urandom_range(0, DEPTH - 1));
          host_addr = a;
          tick();
          n_cmp++; if (host_dout !== model[int'(a)]) begin $display("FAIL rnd_host_rd it=%0d addr=%h got %h want %h", it, a, host_dout, model[int'(a)]); n_fail++; end
        end
      endcase
      n_cmp++; if (err !== model_err) begin $display("FAIL rnd_err it=%0d got %b want %b", it, err, model_err); n_fail++; end
    end
  endtask

  initial begin
    test_reset();
    test_preload_read();
    test_back_to_back();
    test_conflict();
    test_out_of_range();
    test_reset_mid_read();
    test_host_during_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_responder.md
DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 16, meaning data address width in bits.
REQ-002 The module SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-003 The module SHALL have parameter DEPTH, default 1024, meaning the number of implemented words.
REQ-004 The module SHALL have parameter RD_LAT, default 2, meaning the wait cycles between read capture and data valid (range 1..15).
REQ-005 The module SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-006 The module SHALL have port rst_n, input, width 1: reset, asynchronous, active-low.
REQ-007 The module SHALL have port addr_in, input, width ADDR_W: processor data address.
REQ-008 The module SHALL have port din, input, width DATA_W: processor write data.
REQ-009 The module SHALL have port read, input, width 1: processor read request (level).
REQ-010 The module SHALL have port write, input, width 1: processor write request (level).
REQ-011 The module SHALL have port d_out, output, width DATA_W: read data to processor.
REQ-012 The module SHALL have port ready, output, width 1: one-cycle completion strobe.
REQ-013 The module SHALL have port busy, output, width 1: high while in any state other than IDLE.
REQ-014 The module SHALL have port err, output, width 1: sticky error flag.
REQ-015 The module SHALL have ports host_we (input, 1), host_addr (input, ADDR_W), host_din (input, DATA_W) and host_dout (output, DATA_W): the image preload and readback port.

Function
REQ-016 FSM states SHALL be IDLE, RD_WAIT, RD_DONE and WR_DONE.
REQ-017 In IDLE with read=1, write=0, the block SHALL capture addr_in and enter RD_WAIT with wait counter = RD_LAT-1.
REQ-018 In RD_WAIT the counter SHALL decrement each cycle; at 0 the block SHALL load d_out from memory[captured addr] and enter RD_DONE.
REQ-019 In RD_DONE ready SHALL be 1 for exactly one cycle, then the block returns to IDLE; read latency from capture edge to ready = RD_LAT+1 cycles.
REQ-020 In IDLE with write=1, read=0, the block SHALL capture addr_in and din, write memory on that edge, and enter WR_DONE; ready SHALL be 1 for one cycle, then IDLE.
REQ-021 d_out SHALL hold its last read value until the next read completes.
REQ-022 read=1 and write=1 together in IDLE SHALL set err, perform no access, and remain in IDLE.
REQ-023 An address >= DEPTH SHALL set err; a read completes normally with d_out=0, a write completes normally with no memory change.
REQ-024 Deassertion of read or write after capture SHALL NOT abort the operation.
REQ-025 A request still high in IDLE after ready SHALL be treated as a new request (back-to-back allowed, no idle gap required).
REQ-026 host_we=1 in IDLE with no processor request SHALL write host_din to memory[host_addr]; an out-of-range host_addr SHALL be ignored silently.
REQ-027 host_we=1 while busy=1 or coincident with a processor request SHALL be dropped, with the processor request taking priority, and SHALL set err.
REQ-028 host_dout SHALL be memory[host_addr] registered one cycle, independent of FSM state.
REQ-029 err SHALL clear only on reset.

Reset
REQ-030 On rst_n=0, at any time including mid-operation: state=IDLE, counter=0, d_out=0, host_dout=0, ready=0, busy=0, err=0.
REQ-031 Memory contents SHALL NOT be cleared by reset; an in-flight write already committed on its capture edge SHALL persist.

Verification
REQ-032 Bench: host preload 0x0005<-0xA7, then processor read 0x0005 -> ready at capture+3 cycles, d_out=0xA7, busy high for 3 cycles.
REQ-033 Bench: write 0x0010<-0x3C, then read held high continuously on 0x0010 -> ready 1 cycle after write capture, then d_out=0x3C with no idle gap.
REQ-034 Bench: read=write=1 -> err=1, ready stays 0, memory unchanged.
REQ-035 Bench: read 0x0400 (DEPTH=1024) -> ready asserted, d_out=0x00, err=1.
REQ-036 Bench: rst_n low during RD_WAIT -> outputs immediately 0, state IDLE; subsequent read returns pre-reset memory value.
REQ-037 Bench: host_we during an active read -> host write dropped, err=1, read data correct.
